hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised second-generation hazard controller for the 5-stage MIPS pipeline.
- Sits between ID/EX/MEM/WB pipeline registers and PC/IR write enables.
- Adds multi-cycle load-use stall (configurable load latency), memory-wait freeze, taken-branch ID flush and EX-stage forwarding selects, all sequenced by a small FSM.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, total stall cycles inserted per load-use hazard; legal range 1..4.
- PERF_W, 32, width of the stall counter (optional feature only).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- rs_ID  input  REG_AW  rs of instruction in ID.
- rt_ID  input  REG_AW  rt of instruction in ID.
- rs_EX  input  REG_AW  rs of instruction in EX.
- rt_EX  input  REG_AW  rt of instruction in EX.
- wr_EX  input  REG_AW  destination register of instruction in EX.
- MemRead_EX  input  1  instruction in EX is a load.
- wr_MEM  input  REG_AW  destination register in MEM.
- RegWrite_MEM  input  1  MEM instruction writes the register file.
- wr_WB  input  REG_AW  destination register in WB.
- RegWrite_WB  input  1  WB instruction writes the register file.
- branch_taken  input  1  branch resolved taken in EX.
- mem_busy  input  1  data memory not ready this cycle.
- PCWrite  output  1  PC write enable (1 = advance).
- IRWrite  output  1  IF/ID register write enable.
- CtrStr  output  1  1 = pass ID controls to EX; 0 = inject bubble.
- PipeHold  output  1  1 = freeze ID/EX, EX/MEM and MEM/WB registers.
- Flush_ID  output  1  1 = clear IF/ID to NOP.
- ForwardA  output  2  EX operand A source.
- ForwardB  output  2  EX operand B source.
- stall_active  output  1  FSM is not in IDLE.

Behaviour:
- Clock and reset:
  - All state updates on the rising edge of clk.
  - reset is sampled synchronously. While reset is high, the next state is IDLE and the counter clears.
  - While reset is high, outputs are forced to PCWrite=1, IRWrite=1, CtrStr=1, PipeHold=0, Flush_ID=0, ForwardA=ForwardB=00, stall_active=0.
  - Asserting reset mid-stall aborts the stall; normal flow resumes on the cycle after reset deasserts.
- Hazard detect (combinational):
  - lu_hit = MemRead_EX && wr_EX!=0 && (wr_EX==rs_ID || wr_EX==rt_ID).
- FSM states and transitions:
  - IDLE:
    - mem_busy -> MEM_WAIT.
    - else branch_taken -> FLUSH.
    - else lu_hit -> LU_STALL with cnt=LOAD_LAT-1 if LOAD_LAT>1; if LOAD_LAT==1, stay in IDLE.
  - LU_STALL:
    - mem_busy -> MEM_WAIT; cnt is held and resumes after the wait.
    - else cnt==0 -> IDLE.
    - else cnt decrements.
  - MEM_WAIT:
    - Stay while mem_busy.
    - On release, return to LU_STALL if cnt!=0, else IDLE.
  - FLUSH: one cycle, then IDLE.
- Output priority, highest first:
  - reset.
  - mem_busy (any state): PipeHold=1, PCWrite=0, IRWrite=0, CtrStr=1.
  - branch_taken: Flush_ID=1, PCWrite=1, IRWrite=1, CtrStr=0. Flush beats load-use because the ID instruction is discarded.
  - lu_hit, or state LU_STALL: PCWrite=0, IRWrite=0, CtrStr=0.
  - otherwise: normal values (PCWrite=1, IRWrite=1, CtrStr=1, PipeHold=0, Flush_ID=0).
- Stall timing:
  - The first stall cycle is combinational, in the same cycle lu_hit is seen.
  - Total bubbles per load-use hazard = LOAD_LAT exactly.
- stall_active = (state != IDLE).
- Forwarding (combinational, independent of FSM):
  - ForwardA = 01 if RegWrite_MEM && wr_MEM!=0 && wr_MEM==rs_EX.
  - Otherwise ForwardA = 10 if RegWrite_WB && wr_WB!=0 && wr_WB==rs_EX.
  - Otherwise ForwardA = 00.
  - MEM always wins over WB.
  - ForwardB uses identical rules on rt_EX. Code 11 is never driven.
- Register 0 never causes a stall or a forward.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output stall_cycles [PERF_W-1:0].
  - Counter increments by 1 on every cycle PCWrite==0 and reset==0.
  - Wraps from all-ones to 0.
  - Clears on reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LOAD_LAT=1: MemRead_EX=1, wr_EX=8, rs_ID=8 for one cycle -> PCWrite=IRWrite=CtrStr=0 for exactly 1 cycle; stall_active stays 0.
- LOAD_LAT=3: same hazard -> 3 consecutive cycles PCWrite=0, stall_active=1 for cycles 2-3, then IDLE; wr_EX=0 instead -> no stall.
- branch_taken=1 together with lu_hit -> Flush_ID=1, PCWrite=1, CtrStr=0 for 1 cycle; no LU_STALL entry.
- LOAD_LAT=3, mem_busy=1 for 4 cycles during the 2nd stall cycle -> PipeHold=1 for those 4 cycles; the remaining stall cycle completes after release; 3 load-use bubbles in total.
- Forwarding: wr_MEM=5 with RegWrite_MEM=1, wr_WB=5 with RegWrite_WB=1, rs_EX=5 -> ForwardA=01; clear RegWrite_MEM -> ForwardA=10; rt_EX=0 with wr_WB=0 -> ForwardB=00.
- reset=1 asserted in the 2nd cycle of a LOAD_LAT=4 stall -> next cycle IDLE with all outputs at reset values; with HAZARD_PERF_CNT_EN, stall_cycles==0 after reset, then ==2 after a fresh LOAD_LAT=2 hazard.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Second-generation hazard controller for the 5-stage MIPS pipeline. It
//   generates the PC/IR write enables, bubble injection, pipeline freeze and
//   IF/ID flush controls, together with the EX-stage forwarding selects.
//
//   A small FSM sequences three kinds of event:
//     - load-use stalls lasting LOAD_LAT bubbles,
//     - memory-wait freezes,
//     - one-cycle flushes after a taken branch.
//
// Parameters
//   REG_AW    register address width
//   LOAD_LAT  bubbles inserted per load-use hazard (legal range 1..4)
//   PERF_W    width of the optional stall-cycle counter
//
// Ports
//   clk, reset              pipeline clock, synchronous active-high reset
//   rs_ID, rt_ID            source registers of the instruction in ID
//   rs_EX, rt_EX, wr_EX     sources and destination of the instruction in EX
//   MemRead_EX              the instruction in EX is a load
//   wr_MEM, RegWrite_MEM    destination register / write flag in MEM
//   wr_WB, RegWrite_WB      destination register / write flag in WB
//   branch_taken            a branch resolved taken in EX
//   mem_busy                data memory is not ready this cycle
//   PCWrite, IRWrite        PC and IF/ID write enables (1 = advance)
//   CtrStr                  1 = pass ID controls to EX, 0 = inject a bubble
//   PipeHold                freeze the ID/EX, EX/MEM and MEM/WB registers
//   Flush_ID                clear IF/ID to a NOP
//   ForwardA, ForwardB      EX operand sources: 00 = regfile, 01 = MEM, 10 = WB
//   stall_active            the FSM is not in IDLE
//   stall_cycles            (HAZARD_PERF_CNT_EN only) count of cycles with
//                           PCWrite low
//
// Build option
//   HAZARD_PERF_CNT_EN      adds the stall_cycles port and its counter
//
// FSM states
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   IDLE       | normal flow; the first load-use bubble is issued from here
//   LU_STALL   | extra load-use bubbles; cnt = bubbles still owed
//   MEM_WAIT   | pipeline frozen on mem_busy; cnt holds any owed bubbles
//   FLUSH      | one cycle following a taken-branch flush
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs_ID,
   input  logic [REG_AW-1:0] rt_ID,
   input  logic [REG_AW-1:0] rs_EX,
   input  logic [REG_AW-1:0] rt_EX,
   input  logic [REG_AW-1:0] wr_EX,
   input  logic              MemRead_EX,
   input  logic [REG_AW-1:0] wr_MEM,
   input  logic              RegWrite_MEM,
   input  logic [REG_AW-1:0] wr_WB,
   input  logic              RegWrite_WB,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic              PCWrite,
   output logic              IRWrite,
   output logic              CtrStr,
   output logic              PipeHold,
   output logic              Flush_ID,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              stall_active
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   // Out-of-range LOAD_LAT values are clamped into 1..4.
   localparam int LAT_C  = (LOAD_LAT < 1) ? 1 : ((LOAD_LAT > 4) ? 4 : LOAD_LAT);
   localparam int LAT_M1 = LAT_C - 1;
   localparam logic [1:0] CNT_INIT = LAT_M1[1:0];
   localparam logic       MULTI_LAT = (LAT_C > 1);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       lu_hit;
   logic       resume_stall;

   // ---------------------------------------------------------------------------
   // Hazard detect. Register 0 never creates a dependency.
   // ---------------------------------------------------------------------------
   assign lu_hit = MemRead_EX && (wr_EX != '0) &&
                   ((wr_EX == rs_ID) || (wr_EX == rt_ID));

   // When the memory wait ends with bubbles still owed, the release cycle
   // issues the next bubble itself. Otherwise the frozen ID instruction would
   // advance for one cycle in the middle of the stall.
   assign resume_stall = (state_q == MEM_WAIT) && (cnt_q != 2'd0);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      case (state_q)
         IDLE: begin
            cnt_d = 2'd0;
            if (mem_busy) begin
               state_d = MEM_WAIT;
            end else if (branch_taken) begin
               state_d = FLUSH;
            end else if (lu_hit && MULTI_LAT) begin
               // This cycle is the first bubble; LAT_C-1 more are owed.
               state_d = LU_STALL;
               cnt_d   = CNT_INIT;
            end
         end

         LU_STALL: begin
            if (mem_busy) begin
               state_d = MEM_WAIT;
            end else if (cnt_q <= 2'd1) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end

         MEM_WAIT: begin
            if (!mem_busy) begin
               if (cnt_q == 2'd0) begin
                  state_d = IDLE;
               end else if (cnt_q == 2'd1) begin
                  state_d = IDLE;
                  cnt_d   = 2'd0;
               end else begin
                  state_d = LU_STALL;
                  cnt_d   = cnt_q - 2'd1;
               end
            end
         end

         FLUSH: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end

         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
      endcase

      if (reset) begin
         state_d = IDLE;
         cnt_d   = 2'd0;
      end
   end

   // ---------------------------------------------------------------------------
   // Pipeline control outputs. The conditions are tested in priority order:
   // reset, then memory wait, then branch flush, then load-use stall.
   // ---------------------------------------------------------------------------
   always_comb begin
      PCWrite      = 1'b1;
      IRWrite      = 1'b1;
      CtrStr       = 1'b1;
      PipeHold     = 1'b0;
      Flush_ID     = 1'b0;
      stall_active = 1'b0;

      if (!reset) begin
         stall_active = (state_q != IDLE);
         if (mem_busy) begin
            PipeHold = 1'b1;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
         end else if (branch_taken) begin
            // The ID instruction is discarded, so no load-use bubble is needed.
            Flush_ID = 1'b1;
            CtrStr   = 1'b0;
         end else if (lu_hit || (state_q == LU_STALL) || resume_stall) begin
            PCWrite = 1'b0;
            IRWrite = 1'b0;
            CtrStr  = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Forwarding. MEM is the younger result, so it takes priority over WB.
   // ---------------------------------------------------------------------------
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              rw_mem,
      input logic [REG_AW-1:0] dst_mem,
      input logic              rw_wb,
      input logic [REG_AW-1:0] dst_wb
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (rw_mem && (dst_mem != '0) && (dst_mem == src)) begin
         sel = 2'b01;
      end else if (rw_wb && (dst_wb != '0) && (dst_wb == src)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   always_comb begin
      ForwardA = 2'b00;
      ForwardB = 2'b00;
      if (!reset) begin
         ForwardA = fwd_sel(rs_EX, RegWrite_MEM, wr_MEM, RegWrite_WB, wr_WB);
         ForwardB = fwd_sel(rt_EX, RegWrite_MEM, wr_MEM, RegWrite_WB, wr_WB);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // ---------------------------------------------------------------------------
   // Stall-cycle counter. It wraps naturally at all-ones.
   // ---------------------------------------------------------------------------
   logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (reset) begin
         stall_cycles_d = '0;
      end else if (!PCWrite) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wr_ex, wr_mem, wr_wb;
   logic       mem_read, rw_mem, rw_wb, br, busy;

   // Instance k has LOAD_LAT = k+1.
   logic       pcw   [4];
   logic       irw   [4];
   logic       ctr   [4];
   logic       hold  [4];
   logic       flush [4];
   logic [1:0] fa    [4];
   logic [1:0] fb    [4];
   logic       sa    [4];
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] sc   [4];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      hazard_ctrl #(.REG_AW(5), .LOAD_LAT(g + 1), .PERF_W(32)) u_dut (
         .clk          (clk),
         .reset        (reset),
         .rs_ID        (rs_id),
         .rt_ID        (rt_id),
         .rs_EX        (rs_ex),
         .rt_EX        (rt_ex),
         .wr_EX        (wr_ex),
         .MemRead_EX   (mem_read),
         .wr_MEM       (wr_mem),
         .RegWrite_MEM (rw_mem),
         .wr_WB        (wr_wb),
         .RegWrite_WB  (rw_wb),
         .branch_taken (br),
         .mem_busy     (busy),
         .PCWrite      (pcw[g]),
         .IRWrite      (irw[g]),
         .CtrStr       (ctr[g]),
         .PipeHold     (hold[g]),
         .Flush_ID     (flush[g]),
         .ForwardA     (fa[g]),
         .ForwardB     (fb[g]),
         .stall_active (sa[g])
`ifdef HAZARD_PERF_CNT_EN
         ,
         .stall_cycles (sc[g])
`endif
      );
   end

   typedef struct {
      logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wr_ex, wr_mem, wr_wb;
      logic       mem_read, rw_mem, rw_wb, br, busy;
      logic [9:0] exp;   // {pcw,irw,ctr,hold,flush,fa[1:0],fb[1:0],sa}
   } vec_t;

   vec_t vecs[15];

   localparam logic [9:0] NORM = 10'b1110000000;

   function automatic vec_t mk(
      input logic [4:0] a_rs_id, a_rt_id, a_rs_ex, a_rt_ex, a_wr_ex,
      input logic       a_mr,
      input logic [4:0] a_wr_mem,
      input logic       a_rwm,
      input logic [4:0] a_wr_wb,
      input logic       a_rww, a_br, a_busy,
      input logic [9:0] a_exp
   );
      vec_t v;
      v.rs_id = a_rs_id; v.rt_id = a_rt_id; v.rs_ex = a_rs_ex; v.rt_ex = a_rt_ex;
      v.wr_ex = a_wr_ex; v.mem_read = a_mr; v.wr_mem = a_wr_mem; v.rw_mem = a_rwm;
      v.wr_wb = a_wr_wb; v.rw_wb = a_rww; v.br = a_br; v.busy = a_busy;
      v.exp = a_exp;
      return v;
   endfunction

   function automatic logic [9:0] act(input int k);
      return {pcw[k], irw[k], ctr[k], hold[k], flush[k], fa[k], fb[k], sa[k]};
   endfunction

   function automatic logic [3:0] pics(input int k);
      return {pcw[k], irw[k], ctr[k], sa[k]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic clr_in();
      rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; wr_ex = 0; wr_mem = 0; wr_wb = 0;
      mem_read = 0; rw_mem = 0; rw_wb = 0; br = 0; busy = 0;
   endtask

   task automatic set_in(input vec_t v);
      rs_id = v.rs_id; rt_id = v.rt_id; rs_ex = v.rs_ex; rt_ex = v.rt_ex;
      wr_ex = v.wr_ex; mem_read = v.mem_read; wr_mem = v.wr_mem; rw_mem = v.rw_mem;
      wr_wb = v.wr_wb; rw_wb = v.rw_wb; br = v.br; busy = v.busy;
   endtask

   task automatic hazard();
      mem_read = 1; wr_ex = 5'd8; rs_id = 5'd8;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      clr_in();
      @(posedge clk);
      #1 reset = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_a2 [4];
      logic [3:0] exp_a0 [4];
      logic [3:0] exp_b  [8];
      int bubbles, holds;

      // ---------------- reset forces all outputs ----------------
      reset = 1;
      clr_in();
      @(negedge clk);
      hazard(); busy = 1; br = 1;
      rw_mem = 1; wr_mem = 5'd3; rs_ex = 5'd3; rt_ex = 5'd3;
      #1;
      for (int k = 0; k < 4; k++) chk($sformatf("reset_outs_lat%0d", k + 1), 32'(act(k)), 32'(NORM));
      @(negedge clk);
      clr_in();
      @(posedge clk);
      #1 reset = 0;

      // ---------------- table vectors on LOAD_LAT=1 ----------------
      //              rsI rtI rsE rtE wrE mr wrM rwM wrW rwW br bsy  exp
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1110000000);
      vecs[1]  = mk(0, 0, 5, 0, 0, 0, 5, 1, 5, 1, 0, 0, 10'b1110001000);
      vecs[2]  = mk(0, 0, 5, 0, 0, 0, 5, 0, 5, 1, 0, 0, 10'b1110010000);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 10'b1110000000);
      vecs[4]  = mk(0, 0, 3, 7, 0, 0, 7, 1, 3, 1, 0, 0, 10'b1110010010);
      vecs[5]  = mk(8, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 10'b0000000000);
      vecs[6]  = mk(0, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 10'b0000000000);
      vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10'b1110000000);
      vecs[8]  = mk(8, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 10'b1110000000);
      vecs[9]  = mk(8, 0, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0, 10'b1100100000);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1110000001);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b0011000000);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10'b0011000001);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1110000001);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1110000000);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         set_in(vecs[i]);
         #1;
         chk($sformatf("vec%0d", i), 32'(act(0)), 32'(vecs[i].exp));
      end

      // ---------------- LOAD_LAT=3 and LOAD_LAT=1 load-use ----------------
      do_reset();
      exp_a2[0] = 4'b0000; exp_a2[1] = 4'b0001; exp_a2[2] = 4'b0001; exp_a2[3] = 4'b1110;
      exp_a0[0] = 4'b0000; exp_a0[1] = 4'b1110; exp_a0[2] = 4'b1110; exp_a0[3] = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clr_in();
         if (i == 0) hazard();
         #1;
         chk($sformatf("lu3_c%0d", i + 1), 32'(pics(2)), 32'(exp_a2[i]));
         chk($sformatf("lu1_c%0d", i + 1), 32'(pics(0)), 32'(exp_a0[i]));
      end
      @(negedge clk);
      mem_read = 1; wr_ex = 5'd0; rs_id = 5'd0;
      #1 chk("lu3_r0_nostall", 32'(pics(2)), 32'b1110);
      @(negedge clk);
      clr_in();
      #1 chk("lu3_r0_idle", 32'(pics(2)), 32'b1110);

      // ---------------- LOAD_LAT=3 with mem_busy during 2nd stall cycle ----------------
      do_reset();
      // {pcw, ctr, hold, sa}
      exp_b[0] = 4'b0000;
      exp_b[1] = 4'b0111; exp_b[2] = 4'b0111; exp_b[3] = 4'b0111; exp_b[4] = 4'b0111;
      exp_b[5] = 4'b0001; exp_b[6] = 4'b0001; exp_b[7] = 4'b1100;
      bubbles = 0;
      holds = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         clr_in();
         if (i == 0) hazard();
         if (i >= 1 && i <= 4) busy = 1;
         #1;
         chk($sformatf("busy_c%0d", i + 1), 32'({pcw[2], ctr[2], hold[2], sa[2]}), 32'(exp_b[i]));
         if (!ctr[2] && !hold[2]) bubbles++;
         if (hold[2]) holds++;
      end
      chk("busy_bubbles", 32'(bubbles), 32'd3);
      chk("busy_holds", 32'(holds), 32'd4);

      // ---------------- reset aborting a LOAD_LAT=4 stall ----------------
      do_reset();
      @(negedge clk);
      clr_in();
      hazard();
      #1 chk("abort_c1", 32'(pics(3)), 32'b0000);
      @(negedge clk);
      clr_in();
      #1 chk("abort_c2_stall", 32'(pics(3)), 32'b0001);
      reset = 1;
      #1 chk("abort_c2_reset", 32'(act(3)), 32'(NORM));
      @(negedge clk);
      reset = 0;
      #1 chk("abort_c3_idle", 32'(act(3)), 32'(NORM));
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_after_reset", sc[1], 32'd0);
`endif
      @(negedge clk);
      hazard();
      #1 chk("lat2_c1", 32'(pics(1)), 32'b0000);
      @(negedge clk);
      clr_in();
      #1 chk("lat2_c2", 32'(pics(1)), 32'b0001);
      @(negedge clk);
      #1 chk("lat2_c3", 32'(pics(1)), 32'b1110);
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_lat2", sc[1], 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
